afe_buf_wr_arbiter: RTL and testbench

- Round-robin write arbiter for the shared AFE sample buffer write port.
- Shares the port between NUM_ADCS ADC top instances. Each instance raises a request when it has a synchronized sample to store.
- The granted instance sees a one-hot grant (drives its adc_grant_i) and returns a one-cycle acknowledge (its wr_grant_ack_o) when the write completes.
- A programmable watchdog reclaims the port from a requester that never acknowledges.

---
 rtl/afe_buf_wr_arbiter.sv | 77 +++++++
 tb/tb_afe_buf_wr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/afe_buf_wr_arbiter.sv
// afe_buf_wr_arbiter: round-robin arbiter for the shared AFE sample buffer write port
// with a programmable grant watchdog that reclaims the port from silent requesters.
module afe_buf_wr_arbiter #(
   parameter int NUM_ADCS = 4,
   parameter int ID_WIDTH = $clog2(NUM_ADCS),
   parameter int TO_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [NUM_ADCS-1:0] req_i,
   input  logic [NUM_ADCS-1:0] grant_ack_i,
   input  logic [TO_WIDTH-1:0] timeout_lim_i,
   output logic [NUM_ADCS-1:0] grant_o,
   output logic [ID_WIDTH-1:0] grant_id_o,
   output logic                busy_o,
   output logic                timeout_evt_o,
   output logic [ID_WIDTH-1:0] timeout_id_o
);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   state_t              r_state;
   logic [ID_WIDTH-1:0] r_ptr;
   logic [TO_WIDTH-1:0] r_cnt;
   logic [ID_WIDTH-1:0] w_win;
   logic [ID_WIDTH-1:0] w_next_ptr;
   logic                w_ack;
   logic                w_req;
   logic                w_to;
   logic                w_rel;
   // scan downward so the requester closest above the pointer is written last and wins
   always_comb begin
      w_win = '0;
      for (int k = NUM_ADCS - 1; k >= 0; k--)
         if (req_i[ID_WIDTH'((int'(r_ptr) + k) % NUM_ADCS)])
            w_win = ID_WIDTH'((int'(r_ptr) + k) % NUM_ADCS);
   end
   assign w_next_ptr = (int'(grant_id_o) == NUM_ADCS - 1) ? '0 : grant_id_o + ID_WIDTH'(1);
   assign w_ack      = grant_ack_i[grant_id_o];
   assign w_req      = req_i[grant_id_o];
   assign w_to       = (timeout_lim_i != '0) && (r_cnt == timeout_lim_i - TO_WIDTH'(1));
   assign w_rel      = w_ack || !w_req || w_to;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_cnt         <= '0;
         grant_o       <= '0;
         grant_id_o    <= '0;
         busy_o        <= 1'b0;
         timeout_evt_o <= 1'b0;
         timeout_id_o  <= '0;
      end else begin
         timeout_evt_o <= 1'b0;
         if (r_state == S_IDLE) begin
            if (en_i && |req_i) begin
               grant_o    <= NUM_ADCS'(1) << w_win;
               grant_id_o <= w_win;
               busy_o     <= 1'b1;
               r_cnt      <= '0;
               r_state    <= S_GRANT;
            end
         end else if (w_rel) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= S_IDLE;
            // only a pure watchdog expiry is reported; ack or withdrawal take precedence
            if (!w_ack && w_req) begin
               timeout_evt_o <= 1'b1;
               timeout_id_o  <= grant_id_o;
            end
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + TO_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_afe_buf_wr_arbiter.sv
// tb_afe_buf_wr_arbiter: directed self-checking bench for afe_buf_wr_arbiter.
module tb_afe_buf_wr_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] ack = '0;
   logic [7:0] lim = '0;
   logic [3:0] grant;
   logic [1:0] gid;
   logic       busy;
   logic       evt;
   logic [1:0] tid;
   int         n_cmp = 0;
   int         n_err = 0;

   afe_buf_wr_arbiter dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .grant_ack_i(ack),
      .timeout_lim_i(lim), .grant_o(grant), .grant_id_o(gid), .busy_o(busy),
      .timeout_evt_o(evt), .timeout_id_o(tid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_grant"}, 32'(grant), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic check_gnt(input string tag, input int id);
      check({tag, "_grant"}, 32'(grant), 32'(1) << id);
      check({tag, "_gid"}, 32'(gid), 32'(id));
      check({tag, "_busy"}, 32'(busy), 32'h1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      check_idle("rst");
      check("rst_gid", 32'(gid), 0);
      check("rst_evt", 32'(evt), 0);
      check("rst_tid", 32'(tid), 0);

      // single requester ADC2, ack on cycle 3
      req = 4'b0100;
      tick();
      check_gnt("single_c1", 2);
      tick();
      check_gnt("single_c2", 2);
      tick();
      check_gnt("single_c3", 2);
      ack = 4'b0100;
      tick();
      ack = '0;
      req = 4'b0101;
      check_idle("single_c4");
      check("single_evt", 32'(evt), 0);
      tick();
      check_gnt("wrap_adc0", 0);
      ack = 4'b0001;
      tick();
      ack = '0;
      req = '0;
      check_idle("wrap_rel");

      // round robin with all requesting
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 6; i++) begin
         check_gnt($sformatf("rr%0d", i), i % 4);
         check($sformatf("rr%0d_onehot", i), 32'($onehot0(grant)), 1);
         tick();
         check_gnt($sformatf("rr%0d_hold", i), i % 4);
         ack = 4'(1 << (i % 4));
         tick();
         ack = '0;
         check_idle($sformatf("rr%0d_gap", i));
         tick();
      end
      check_gnt("rr_next", 2);
      req = '0;
      tick();
      check_idle("rr_withdraw");
      check("rr_withdraw_evt", 32'(evt), 0);

      // watchdog: ADC1 never acks, ADC2 waiting (pointer is 3)
      lim = 8'd5;
      req = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_gnt($sformatf("wd_c%0d", i), 1);
         check($sformatf("wd_c%0d_evt", i), 32'(evt), 0);
      end
      tick();
      check_idle("wd_rel");
      check("wd_evt", 32'(evt), 1);
      check("wd_tid", 32'(tid), 1);
      tick();
      check("wd_evt_pulse", 32'(evt), 0);
      check("wd_tid_hold", 32'(tid), 1);
      check_gnt("wd_next", 2);
      req = '0;
      tick();
      check_idle("wd_next_rel");

      // ack coincident with timeout (pointer 3)
      lim = 8'd3;
      req = 4'b0001;
      tick();
      check_gnt("coin_c1", 0);
      tick();
      tick();
      check_gnt("coin_c3", 0);
      ack = 4'b0001;
      tick();
      ack = '0;
      req = '0;
      check_idle("coin_rel");
      check("coin_evt", 32'(evt), 0);
      check("coin_tid", 32'(tid), 1);

      // stray ack ignored, withdrawal releases (pointer 1)
      lim = '0;
      req = 4'b0100;
      tick();
      check_gnt("stray_g", 2);
      ack = 4'b0001;
      tick();
      ack = '0;
      check_gnt("stray_hold", 2);
      req = '0;
      tick();
      check_idle("stray_rel");
      check("stray_evt", 32'(evt), 0);

      // en_i gating and reset mid-grant
      do_reset();
      en = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("en0_c%0d", i), 32'(grant), 0);
      end
      en = 1'b1;
      tick();
      check_gnt("en1", 0);
      en = 1'b0;
      ack = 4'b0001;
      tick();
      ack = '0;
      check_idle("en0_complete");
      en = 1'b1;
      tick();
      check_gnt("pre_rst", 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("mid_rst");
      check("mid_rst_gid", 32'(gid), 0);
      check("mid_rst_evt", 32'(evt), 0);
      tick();
      check_gnt("post_rst", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
